// File: rtl/multicycle_ctrl.sv
// Multicycle RV32/RV64 control FSM: fetch/decode/exec/mem/wb sequencing, decode of
// datapath selects, handshake timeouts and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int XLEN    = 32,
    parameter int EN_M    = 0,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [31:0]     inst,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    input  logic            is_zero,
    input  logic            less,
    output logic [2:0]      op_imm,
    output logic            alu_asrc,
    output logic [1:0]      alu_bsrc,
    output logic [4:0]      alu_sel,
    output logic            rf_we,
    output logic            pc_we,
    output logic [1:0]      pc_sel,
    output logic [2:0]      state,
    output logic            halted,
    output logic            trap,
    output logic [XLEN-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_U = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_S = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_ADDW = 5'd26;
    localparam logic [4:0] ALU_SUBW = 5'd27;
    localparam logic [4:0] ALU_SLLW = 5'd28;
    localparam logic [4:0] ALU_SRLW = 5'd29;
    localparam logic [4:0] ALU_SRAW = 5'd30;
    localparam logic [4:0] ALU_MULW = 5'd31;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    state_e          state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic [7:0]      tmo_q, tmo_d;

    logic [6:0] opcode, f7, f7_sh;
    logic [2:0] f3;
    logic       legal, is_ld, is_st, is_br, is_jal, is_jalr, taken, retire;

    function automatic logic [4:0] alu_base(input logic [2:0] fn3, input logic alt);
        case (fn3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // Decode depends only on IR, which is frozen from DECODE through WB.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        opcode   = ir_q[6:0];
        f3       = ir_q[14:12];
        f7       = ir_q[31:25];
        f7_sh    = (XLEN == 64) ? {ir_q[31:26], 1'b0} : f7;
        legal    = 1'b0;
        is_ld    = 1'b0;
        is_st    = 1'b0;
        is_br    = 1'b0;
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        op_imm   = IMM_I;
        alu_asrc = 1'b0;
        alu_bsrc = 2'b01;
        alu_sel  = ALU_ADD;
        case (opcode)
            OPC_LUI:   begin legal = 1'b1; op_imm = IMM_U; end
            OPC_AUIPC: begin legal = 1'b1; op_imm = IMM_U; alu_asrc = 1'b1; end
            OPC_JAL: begin
                legal = 1'b1; is_jal = 1'b1; op_imm = IMM_J;
                alu_asrc = 1'b1; alu_bsrc = 2'b10;
            end
            OPC_JALR: begin
                legal = (f3 == 3'b000); is_jalr = 1'b1;
                alu_asrc = 1'b1; alu_bsrc = 2'b10;
            end
            OPC_BRANCH: begin
                legal = (f3[2:1] != 2'b01); is_br = 1'b1; op_imm = IMM_B; alu_bsrc = 2'b00;
                alu_sel = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
            end
            OPC_LOAD: begin
                is_ld = 1'b1;
                legal = (f3 != 3'b111) && ((XLEN == 64) || (f3 != 3'b011 && f3 != 3'b110));
            end
            OPC_STORE: begin
                is_st = 1'b1; op_imm = IMM_S;
                legal = !f3[2] && ((XLEN == 64) || (f3 != 3'b011));
            end
            OPC_OPIMM: begin
                alu_sel = alu_base(f3, ir_q[30]);
                if (f3 == 3'b001)      legal = (f7_sh == F7_ZERO);
                else if (f3 == 3'b101) legal = (f7_sh == F7_ZERO) || (f7_sh == F7_ALT);
                else                   legal = 1'b1;
            end
            OPC_OP: begin
                alu_bsrc = 2'b00;
                if (f7 == F7_ZERO) begin
                    legal = 1'b1; alu_sel = alu_base(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    legal = 1'b1; alu_sel = alu_base(f3, 1'b1);
                end else if (f7 == F7_MUL && EN_M != 0) begin
                    legal = 1'b1; alu_sel = {2'b10, f3};
                end
            end
            OPC_OPIMMW: begin
                legal = (XLEN == 64) && ((f3 == 3'b000) || (f3 == 3'b001 && f7 == F7_ZERO) ||
                        (f3 == 3'b101 && (f7 == F7_ZERO || f7 == F7_ALT)));
                alu_sel = (f3 == 3'b000) ? ALU_ADDW : (f3 == 3'b001) ? ALU_SLLW :
                          (ir_q[30] ? ALU_SRAW : ALU_SRLW);
            end
            OPC_OPW: begin
                // Only MULW has a W-suffix slot in the ALU op encoding.
                alu_bsrc = 2'b00;
                legal = (XLEN == 64) && (
                        (f7 == F7_ZERO && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) ||
                        (f7 == F7_ALT  && (f3 == 3'b000 || f3 == 3'b101)) ||
                        (f7 == F7_MUL  && f3 == 3'b000 && EN_M != 0));
                alu_sel = (f7 == F7_MUL) ? ALU_MULW :
                          (f3 == 3'b000) ? (f7[5] ? ALU_SUBW : ALU_ADDW) :
                          (f3 == 3'b001) ? ALU_SLLW : (f7[5] ? ALU_SRAW : ALU_SRLW);
            end
            default: legal = 1'b0;
        endcase
    end

    assign taken = (f3[2] ? less : is_zero) ^ f3[0];

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        retire    = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_d    = inst;
                    state_d = S_DECODE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                if (ir_q == INST_EBREAK) state_d = S_HALT;
                else if (!legal)         state_d = S_TRAP;
                else                     state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_br) begin
                    pc_we   = 1'b1;
                    pc_sel  = taken ? 2'b01 : 2'b00;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_ready) begin
                    retire  = is_st;
                    state_d = is_st ? S_FETCH : S_WB;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        instret_d = retire ? instret_q + ONE : instret_q;
        tmo_d     = (state_d != state_q || (state_q != S_FETCH && state_q != S_MEM))
                    ? 8'd0 : tmo_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ir_q      <= INST_NOP;
            instret_q <= '0;
            tmo_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            tmo_q     <= tmo_d;
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign trap    = (state_q == S_TRAP);
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: one EN_M=0 and one EN_M=1 instance share stimulus;
// inputs change and outputs are sampled on the falling edge.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, imem_ready, dmem_ready, is_zero, less;
    logic [31:0] inst;

    logic        imem_req, dmem_req, dmem_we, alu_asrc, rf_we, pc_we, halted, trap;
    logic [2:0]  op_imm, state;
    logic [1:0]  alu_bsrc, pc_sel;
    logic [4:0]  alu_sel;
    logic [31:0] instret;

    logic        m_imem_req, m_dmem_req, m_dmem_we, m_alu_asrc, m_rf_we, m_pc_we, m_halted, m_trap;
    logic [2:0]  m_op_imm, m_state;
    logic [1:0]  m_alu_bsrc, m_pc_sel;
    logic [4:0]  m_alu_sel;
    logic [31:0] m_instret;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.XLEN(32), .EN_M(0), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ready(imem_ready), .inst(inst),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .is_zero(is_zero), .less(less), .op_imm(op_imm), .alu_asrc(alu_asrc),
        .alu_bsrc(alu_bsrc), .alu_sel(alu_sel), .rf_we(rf_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .state(state), .halted(halted), .trap(trap), .instret(instret)
    );

    multicycle_ctrl #(.XLEN(32), .EN_M(1), .TIMEOUT(16)) dut_m (
        .clk(clk), .rst_n(rst_n), .imem_req(m_imem_req), .imem_ready(imem_ready), .inst(inst),
        .dmem_req(m_dmem_req), .dmem_we(m_dmem_we), .dmem_ready(dmem_ready),
        .is_zero(is_zero), .less(less), .op_imm(m_op_imm), .alu_asrc(m_alu_asrc),
        .alu_bsrc(m_alu_bsrc), .alu_sel(m_alu_sel), .rf_we(m_rf_we), .pc_we(m_pc_we),
        .pc_sel(m_pc_sel), .state(m_state), .halted(m_halted), .trap(m_trap), .instret(m_instret)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called in a FETCH cycle; returns in the DECODE cycle.
    task automatic fetch(input logic [31:0] word);
        check("fetch_state", state, 3'd0);
        inst       = word;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("decode_state", state, 3'd1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", state, 3'd0);
        check("rst_instret", instret, 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        is_zero = 1'b0; less = 1'b0; inst = 32'h0;

        // Reset state; IR resets to NOP (addi)
        tick(); tick();
        check("reset_state", state, 3'd0);
        check("reset_instret", instret, 32'd0);
        check("reset_halted", halted, 1'b0);
        check("reset_trap", trap, 1'b0);
        check("reset_nop_sel", alu_sel, 5'd0);
        check("reset_nop_bsrc", alu_bsrc, 2'b01);
        rst_n = 1'b1;
        check("first_imem_req", imem_req, 1'b1);

        // addi x1,x0,5: 0,1,2,4,0
        fetch(32'h0050_0093);
        check("addi_opimm", op_imm, 3'd0);
        check("addi_sel", alu_sel, 5'd0);
        check("addi_bsrc", alu_bsrc, 2'b01);
        check("addi_dec_rfwe", rf_we, 1'b0);
        tick();
        check("addi_exec", state, 3'd2);
        check("addi_exec_rfwe", rf_we, 1'b0);
        tick();
        check("addi_wb", state, 3'd4);
        check("addi_wb_rfwe", rf_we, 1'b1);
        check("addi_wb_pcwe", pc_we, 1'b1);
        check("addi_wb_pcsel", pc_sel, 2'b00);
        tick();
        check("addi_done", state, 3'd0);
        check("addi_rfwe_off", rf_we, 1'b0);
        check("addi_instret", instret, 32'd1);

        // beq taken: 3-cycle, pc_sel=01 in EXEC
        fetch(32'h0020_8463);
        check("beq_opimm", op_imm, 3'd2);
        check("beq_sel", alu_sel, 5'd1);
        is_zero = 1'b1;
        tick();
        check("beq_exec", state, 3'd2);
        check("beq_pcwe", pc_we, 1'b1);
        check("beq_pcsel", pc_sel, 2'b01);
        check("beq_rfwe", rf_we, 1'b0);
        tick();
        check("beq_done", state, 3'd0);
        check("beq_instret", instret, 32'd2);

        // bne with is_zero=1: not taken
        fetch(32'h0020_9463);
        tick();
        check("bne_pcwe", pc_we, 1'b1);
        check("bne_pcsel", pc_sel, 2'b00);
        tick();
        is_zero = 1'b0;
        check("bne_instret", instret, 32'd3);

        // lw with dmem_ready low 3 cycles
        fetch(32'h0000_A183);
        tick();
        check("lw_exec_dreq", dmem_req, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lw_mem_state", state, 3'd3);
            check("lw_mem_dreq", dmem_req, 1'b1);
            check("lw_mem_we", dmem_we, 1'b0);
            tick();
        end
        check("lw_mem4_dreq", dmem_req, 1'b1);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        check("lw_wb", state, 3'd4);
        check("lw_wb_rfwe", rf_we, 1'b1);
        check("lw_wb_dreq", dmem_req, 1'b0);
        tick();
        check("lw_instret", instret, 32'd4);

        // jal x1,8: link PC+4, pc_sel=01 in WB
        fetch(32'h0080_00EF);
        check("jal_opimm", op_imm, 3'd4);
        check("jal_asrc", alu_asrc, 1'b1);
        check("jal_bsrc", alu_bsrc, 2'b10);
        tick(); tick();
        check("jal_wb_pcsel", pc_sel, 2'b01);
        tick();
        check("jal_instret", instret, 32'd5);

        // ebreak -> HALT, terminal, no strobes
        fetch(32'h0010_0073);
        tick();
        check("ebreak_state", state, 3'd5);
        check("ebreak_halted", halted, 1'b1);
        imem_ready = 1'b1;
        tick(); tick();
        check("halt_stays", state, 3'd5);
        check("halt_imem_req", imem_req, 1'b0);
        check("halt_pcwe", pc_we, 1'b0);
        check("halt_instret", instret, 32'd5);
        imem_ready = 1'b0;
        pulse_reset();
        check("halt_cleared", halted, 1'b0);

        // Handshake on the 16th FETCH cycle wins over the timeout
        repeat (15) tick();
        check("fetch15_state", state, 3'd0);
        fetch(32'h0050_0093);
        tick(); tick(); tick();
        check("late_fetch_instret", instret, 32'd1);

        // FETCH timeout
        repeat (15) tick();
        check("fetch_tmo_pre", state, 3'd0);
        tick();
        check("fetch_tmo_state", state, 3'd6);
        check("fetch_tmo_trap", trap, 1'b1);
        check("fetch_tmo_imem", imem_req, 1'b0);
        pulse_reset();

        // mul: EN_M=0 traps, EN_M=1 decodes as alu_sel 16
        fetch(32'h0220_8033);
        check("mulm_sel", m_alu_sel, 5'd16);
        tick();
        check("mul_nom_trap", state, 3'd6);
        check("mulm_exec", m_state, 3'd2);
        tick();
        check("mulm_wb", m_state, 3'd4);
        check("mulm_wb_rfwe", m_rf_we, 1'b1);
        check("mulm_wb_sel", m_alu_sel, 5'd16);
        tick();
        check("mulm_instret", m_instret, 32'd1);
        pulse_reset();

        // sw with immediate handshake retires without WB
        fetch(32'h0020_A023);
        check("sw_opimm", op_imm, 3'd3);
        tick(); tick();
        check("sw_mem_we", dmem_we, 1'b1);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        check("sw_done", state, 3'd0);
        check("sw_instret", instret, 32'd1);

        // sw with dmem_ready never asserted -> TRAP after 16 MEM cycles
        fetch(32'h0020_A023);
        tick(); tick();
        repeat (15) tick();
        check("sw_mem16_state", state, 3'd3);
        check("sw_mem16_dreq", dmem_req, 1'b1);
        tick();
        check("sw_tmo_state", state, 3'd6);
        check("sw_tmo_trap", trap, 1'b1);
        check("sw_tmo_dreq", dmem_req, 1'b0);
        check("sw_tmo_instret", instret, 32'd1);
        repeat (4) tick();
        check("trap_sticky", trap, 1'b1);
        pulse_reset();
        check("trap_cleared", trap, 1'b0);

        // Reset mid-MEM drops dmem_req immediately
        fetch(32'h0020_A023);
        tick(); tick();
        check("midmem_dreq", dmem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmem_rst_dreq", dmem_req, 1'b0);
        check("midmem_rst_state", state, 3'd0);
        check("midmem_rst_instret", instret, 32'd0);
        tick();
        rst_n = 1'b1;

        // Illegal opcode
        fetch(32'hFFFF_FFFF);
        tick();
        check("illegal_trap", trap, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter EN_M, default 0, meaning 1 enables RV M-extension decode.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum wait in cycles for any memory handshake, range 2..255.
REQ-004 SHALL have one clock; reset is asynchronous and active-low (ports clk and rst_n).
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_ready  input  1  inst valid; handshake completes when imem_req and imem_ready are both high.
REQ-009 inst  input  32  instruction word, sampled on the imem handshake.
REQ-010 dmem_req / dmem_we  output  1 / 1  data access request / store enable.
REQ-011 dmem_ready  input  1  data handshake complete.
REQ-012 is_zero, less  input  1 each  ALU flags, valid in EXEC.
REQ-013 op_imm  output  3  immediate format: I=0, U=1, B=2, S=3, J=4.
REQ-014 alu_asrc  output  1  0 = rs1, 1 = PC.
REQ-015 alu_bsrc  output  2  00 = rs2, 01 = imm, 10 = constant 4.
REQ-016 alu_sel  output  5  ALU op: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, MUL..REMU 16..23, W-suffix = bit4 set with op 10..15.
REQ-017 rf_we, pc_we  output  1 each  register-file and PC write strobes.
REQ-018 pc_sel  output  2  00 = PC+4, 01 = PC+imm, 10 = (rs1+imm)&~1.
REQ-019 state  output  3  current FSM state encoding.
REQ-020 halted, trap  output  1 each  sticky ebreak-halt / illegal-or-timeout flags.
REQ-021 instret  output  XLEN  retired-instruction counter.

Function
REQ-022 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
REQ-023 FETCH: imem_req=1; on handshake, latch inst into IR and go to DECODE; after TIMEOUT cycles without imem_ready, go to TRAP.
REQ-024 DECODE: 1 cycle; decodes the IR; an illegal opcode, funct3 or funct7 goes to TRAP; ebreak (0x00100073) goes to HALT; otherwise goes to EXEC.
REQ-025 Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; OP-IMM-32 and OP-32 are legal only when XLEN=64.
REQ-026 OP with funct7=0000001 is legal only when EN_M=1; it maps to alu_sel 16+funct3.
REQ-027 funct7 bit5 selects SUB/SRA only for OP funct3 000/101 and OP-IMM funct3 101; any other nonzero funct7 is illegal.
REQ-028 op_imm, alu_asrc, alu_bsrc and alu_sel SHALL be held constant from DECODE through WB of one instruction.
REQ-029 EXEC: 1 cycle; a LOAD or STORE goes to MEM; a BRANCH drives pc_we=1 and goes to FETCH; all other instructions go to WB.
REQ-030 Branch taken conditions: BEQ is_zero, BNE !is_zero, BLT/BLTU less, BGE/BGEU !less; taken gives pc_sel=01, not taken gives 00.
REQ-031 MEM: dmem_req=1 and dmem_we=store; a load goes to WB and a store goes to FETCH on handshake; after TIMEOUT cycles, go to TRAP.
REQ-032 WB: rf_we=1 for exactly one cycle and pc_we=1 in the same cycle; JAL gives pc_sel 01, JALR gives 10, others give 00; then go to FETCH.
REQ-033 JAL/JALR SHALL use alu_asrc=1 and alu_bsrc=10 (link = PC+4); LUI uses imm with rs1 forced to x0 in the datapath.
REQ-034 instret SHALL increment by 1, wrapping modulo 2^XLEN, on each instruction exit from EXEC, MEM or WB to FETCH.
REQ-035 HALT and TRAP SHALL be terminal and assert no strobes; halted=1 in HALT and trap=1 in TRAP; only reset exits them.
REQ-036 The timeout counter SHALL clear on every state entry; a handshake arriving on the TIMEOUT-th cycle wins over the timeout.
REQ-037 rf_we, pc_we, imem_req and dmem_req SHALL be combinational from state and the IR only, never from the ready inputs.
REQ-038 The block SHALL NOT call halt through DPI; the testbench observes the halted output.

Reset
REQ-039 When rst_n=0, asynchronously: state=FETCH, IR=0x00000013 (NOP), instret=0, halted=0, trap=0, timeout counter=0.
REQ-040 Reset asserted mid-MEM SHALL drop dmem_req in the same cycle; the interrupted store does not retire.
REQ-041 The first imem_req SHALL assert in the first cycle after rst_n rises.

Verification
REQ-042 addi x1,x0,5 fetched with imem_ready on cycle 0 -> state sequence 0,1,2,4,0; rf_we high one cycle; instret=1.
REQ-043 beq with is_zero=1 -> pc_we=1 with pc_sel=01 in EXEC; rf_we never asserts; 3-cycle instruction.
REQ-044 lw with dmem_ready held low 3 cycles, then high -> dmem_req high 4 cycles, dmem_we=0, WB follows, rf_we pulses.
REQ-045 sw with dmem_ready never asserted and TIMEOUT=16 -> TRAP after 16 MEM cycles; trap=1 and stays until reset.
REQ-046 inst=0x02208033 (mul): EN_M=0 -> TRAP from DECODE; EN_M=1 -> alu_sel=16 and normal WB.
REQ-047 ebreak -> HALT after DECODE with halted=1; rst_n pulsed low -> state=0, halted=0, instret=0.
